// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential arithmetic unit: operation encoding
// and the controller state type.
package seq_arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_ITER = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative datapath: LSB-first shift-add multiply and restoring divide,
// one bit per cycle, W cycles per operation after a start pulse.
module seq_muldiv_core #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           is_div,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] res
);

    localparam int CW = $clog2(W + 1);

    logic           busy_r;
    logic           div_mode_r;
    logic [CW-1:0]  cnt_r;
    logic [2*W-1:0] acc_r;
    logic [2*W-1:0] mcand_r;
    logic [W-1:0]   q_r;
    logic [W-1:0]   dvs_r;

    logic [2*W-1:0] acc_n_s;
    logic [2*W-1:0] mcand_n_s;
    logic [W-1:0]   q_n_s;
    logic [W-1:0]   rem_n_s;
    logic [W:0]     rsh_s;
    logic [W:0]     diff_s;
    logic           last_s;

    // done flags the edge that performs the final step, so res is the
    // value the datapath registers take on that same edge
    assign last_s = busy_r && (cnt_r == CW'(W - 1));
    assign done   = last_s;

    // Next-step arithmetic for whichever operation is in flight
    always_comb begin
        rsh_s     = {acc_r[W-1:0], q_r[W-1]};
        diff_s    = rsh_s - {1'b0, dvs_r};
        mcand_n_s = {mcand_r[2*W-2:0], 1'b0};
        rem_n_s   = {W{1'b0}};
        q_n_s     = q_r;
        acc_n_s   = acc_r;
        res       = {(2*W){1'b0}};
        if (div_mode_r) begin
            // Borrow out of the trial subtract means the divisor did not fit
            if (diff_s[W]) begin
                rem_n_s = rsh_s[W-1:0];
                q_n_s   = {q_r[W-2:0], 1'b0};
            end else begin
                rem_n_s = diff_s[W-1:0];
                q_n_s   = {q_r[W-2:0], 1'b1};
            end
            acc_n_s = {{W{1'b0}}, rem_n_s};
            res     = {rem_n_s, q_n_s};
        end else begin
            acc_n_s = acc_r + (q_r[0] ? mcand_r : {(2*W){1'b0}});
            q_n_s   = {1'b0, q_r[W-1:1]};
            res     = acc_n_s;
        end
    end

    // Operand load on start, one iteration per cycle while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r     <= 1'b0;
            div_mode_r <= 1'b0;
            cnt_r      <= {CW{1'b0}};
            acc_r      <= {(2*W){1'b0}};
            mcand_r    <= {(2*W){1'b0}};
            q_r        <= {W{1'b0}};
            dvs_r      <= {W{1'b0}};
        end else if (start) begin
            busy_r     <= 1'b1;
            div_mode_r <= is_div;
            cnt_r      <= {CW{1'b0}};
            acc_r      <= {(2*W){1'b0}};
            if (is_div) begin
                mcand_r <= {(2*W){1'b0}};
                q_r     <= a;
                dvs_r   <= b;
            end else begin
                mcand_r <= {{W{1'b0}}, a};
                q_r     <= b;
                dvs_r   <= {W{1'b0}};
            end
        end else if (busy_r) begin
            acc_r   <= acc_n_s;
            mcand_r <= mcand_n_s;
            q_r     <= q_n_s;
            cnt_r   <= cnt_r + CW'(1);
            busy_r  <= !last_s;
        end
    end

endmodule

// File: rtl/seq_arith_unit.sv
// Sequential unsigned arithmetic unit: ADD/SUB (and divide-by-zero) finish in
// one execute cycle, MUL/DIV iterate W cycles in seq_muldiv_core.
module seq_arith_unit
    import seq_arith_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] result,
    output logic           err
);

    state_t         state_r;
    state_t         state_n_s;
    logic [1:0]     op_r;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [2*W-1:0] result_r;
    logic           err_r;
    logic           out_valid_r;
    logic           in_ready_r;

    logic           accept_s;
    logic           start_s;
    logic           load_s;
    logic [2*W-1:0] res_n_s;
    logic           err_n_s;
    logic [2*W:0]   exec_s;
    logic           core_done_s;
    logic [2*W-1:0] core_res_s;

    // Single-cycle operations; returns {err, result}
    function automatic logic [2*W:0] exec_calc(
        input logic [1:0]   f_op,
        input logic [W-1:0] f_a,
        input logic [W-1:0] f_b
    );
        logic [2*W-1:0] ext_a;
        logic [2*W-1:0] ext_b;
        ext_a = {{W{1'b0}}, f_a};
        ext_b = {{W{1'b0}}, f_b};
        case (f_op)
            OP_ADD:  exec_calc = {1'b0, ext_a + ext_b};
            OP_SUB:  exec_calc = {1'b0, ext_a - ext_b};
            OP_DIV:  exec_calc = {1'b1, f_a, {W{1'b1}}};
            default: exec_calc = {(2*W+1){1'b0}};
        endcase
    endfunction

    assign accept_s  = in_valid && (state_r == ST_IDLE);
    assign exec_s    = exec_calc(op_r, a_r, b_r);
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign err       = err_r;

    seq_muldiv_core #(.W(W)) u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (start_s),
        .is_div (op == OP_DIV),
        .a      (a),
        .b      (b),
        .done   (core_done_s),
        .res    (core_res_s)
    );

    // Controller next-state and result selection
    always_comb begin
        state_n_s = state_r;
        start_s   = 1'b0;
        load_s    = 1'b0;
        res_n_s   = result_r;
        err_n_s   = err_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if ((op == OP_MUL) || ((op == OP_DIV) && (b != {W{1'b0}}))) begin
                        state_n_s = ST_ITER;
                        start_s   = 1'b1;
                    end else begin
                        state_n_s = ST_EXEC;
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_n_s          = ST_DONE;
                load_s             = 1'b1;
                {err_n_s, res_n_s} = exec_s;
            end
            ST_ITER: begin
                if (core_done_s) begin
                    state_n_s = ST_DONE;
                    load_s    = 1'b1;
                    res_n_s   = core_res_s;
                    err_n_s   = 1'b0;
                end else begin
                    state_n_s = ST_ITER;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_DONE;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State, handshake flags and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            result_r    <= {(2*W){1'b0}};
            err_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_n_s;
            out_valid_r <= (state_n_s == ST_DONE);
            in_ready_r  <= (state_n_s == ST_IDLE);
            if (load_s) begin
                result_r <= res_n_s;
                err_r    <= err_n_s;
            end
        end
    end

    // Operand capture so later input changes cannot disturb the transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r <= 2'b00;
            a_r  <= {W{1'b0}};
            b_r  <= {W{1'b0}};
        end else if (accept_s) begin
            op_r <= op;
            a_r  <= a;
            b_r  <= b;
        end
    end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Self-checking bench for seq_arith_unit (W=8): directed cases, boundary
// operands, random transactions against a plain-arithmetic model, and reset abort.
module tb_seq_arith_unit;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic           err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_arith_unit #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: result, err and latency straight from the arithmetic rules
    task automatic ref_model(input logic [1:0] f_op, input logic [W-1:0] f_a,
                             input logic [W-1:0] f_b, output logic [2*W-1:0] r,
                             output logic e, output int lat);
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] t;
        ua = {24'd0, f_a};
        ub = {24'd0, f_b};
        e  = 1'b0;
        case (f_op)
            2'd0: t = ua + ub;
            2'd1: t = ua - ub;
            2'd2: t = ua * ub;
            default: begin
                if (ub == 32'd0) begin
                    t = {16'd0, f_a, 8'hFF};
                    e = 1'b1;
                end else begin
                    t = ((ua % ub) << W) | (ua / ub);
                end
            end
        endcase
        r   = t[2*W-1:0];
        lat = ((f_op == 2'd2) || ((f_op == 2'd3) && (ub != 32'd0))) ? W + 1 : 2;
    endtask

    task automatic txn(input logic [1:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                       input int hold, input logic [2*W-1:0] exp_r, input logic exp_e,
                       input int exp_lat, input string tag);
        int lat;
        bit seen;
        @(negedge clk);
        op = t_op; a = t_a; b = t_b; in_valid = 1'b1; out_ready = 1'b0;
        chk({tag, ":in_ready_idle"}, in_ready, 1);
        @(posedge clk);
        #1;
        // Scramble inputs and poke the handshakes while busy
        in_valid = 1'($urandom); out_ready = 1'($urandom);
        op = 2'($urandom); a = W'($urandom); b = W'($urandom);
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                lat  = c;
            end else begin
                chk({tag, ":in_ready_busy"}, in_ready, 0);
                in_valid = 1'($urandom); out_ready = 1'($urandom);
                op = 2'($urandom); a = W'($urandom); b = W'($urandom);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({tag, ":latency"}, lat, exp_lat);
        if (!seen) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        chk({tag, ":result"}, result, exp_r);
        chk({tag, ":err"}, err, exp_e);
        in_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, ":hold_result"}, result, exp_r);
            chk({tag, ":hold_valid"}, out_valid, 1);
            chk({tag, ":hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ":drain_valid"}, out_valid, 0);
        chk({tag, ":drain_in_ready"}, in_ready, 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [1:0]     r_op;
        logic [W-1:0]   r_a;
        logic [W-1:0]   r_b;
        logic [2*W-1:0] r_res;
        logic           r_err;
        int             r_lat;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 2'd0; a = 8'd0; b = 8'd0;
        repeat (2) @(negedge clk);
        chk("reset:out_valid", out_valid, 0);
        chk("reset:in_ready", in_ready, 1);
        chk("reset:result", result, 0);
        chk("reset:err", err, 0);
        rst = 1'b0;

        txn(2'd0, 8'd200, 8'd100, 0, 16'h012C, 1'b0, 2, "add_200_100");
        txn(2'd1, 8'd3,   8'd5,   0, 16'hFFFE, 1'b0, 2, "sub_3_5");
        txn(2'd2, 8'd255, 8'd255, 0, 16'hFE01, 1'b0, 9, "mul_255_255");
        txn(2'd3, 8'd200, 8'd7,   0, 16'h041C, 1'b0, 9, "div_200_7");
        txn(2'd3, 8'd5,   8'd0,   5, 16'h05FF, 1'b1, 2, "div_5_0_hold");
        txn(2'd0, 8'd255, 8'd255, 1, 16'h01FE, 1'b0, 2, "add_carry");
        txn(2'd1, 8'd0,   8'd255, 0, 16'hFF01, 1'b0, 2, "sub_wrap");
        txn(2'd2, 8'd0,   8'd255, 0, 16'h0000, 1'b0, 9, "mul_zero");
        txn(2'd3, 8'd255, 8'd1,   0, 16'h00FF, 1'b0, 9, "div_by_1");
        txn(2'd3, 8'd3,   8'd200, 2, 16'h0300, 1'b0, 9, "div_small");
        txn(2'd3, 8'd255, 8'd255, 0, 16'h0001, 1'b0, 9, "div_equal");

        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = W'($urandom);
            r_b  = W'($urandom);
            if ((r_op == 2'd3) && ($urandom_range(0, 3) == 0)) r_b = 8'd0;
            ref_model(r_op, r_a, r_b, r_res, r_err, r_lat);
            txn(r_op, r_a, r_b, $urandom_range(0, 3), r_res, r_err, r_lat, "random");
        end

        // Abort a multiply mid-iteration with reset
        @(negedge clk);
        op = 2'd2; a = 8'd13; b = 8'd11; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort:out_valid", out_valid, 0);
        chk("abort:in_ready", in_ready, 1);
        chk("abort:result", result, 0);
        chk("abort:err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("abort:no_output", out_valid, 0);
        end
        txn(2'd0, 8'd1, 8'd1, 0, 16'h0002, 1'b0, 2, "add_after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/seq_arith_unit.md
SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

Interface
REQ-001 Parameter W SHALL default to 8 and set operand width; legal values are 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  request present on op/a/b.
REQ-005 in_ready  output  1  unit can accept a request.
REQ-006 op  input  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 DIV (all unsigned).
REQ-007 a, b  input  W each  operands.
REQ-008 out_valid  output  1  result and err are valid.
REQ-009 out_ready  input  1  consumer takes the result.
REQ-010 result  output  2W  operation result.
REQ-011 err  output  1  divide-by-zero flag, qualified by out_valid.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, EXEC, ITER and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where in_valid and in_ready are both 1.
REQ-014 On accept, op, a and b SHALL be registered; later input changes SHALL not affect the transaction.
REQ-015 On accept, ADD, SUB, and DIV with b=0 SHALL go to EXEC; MUL, and DIV with b!=0, SHALL go to ITER with the iteration counter cleared.
REQ-016 EXEC SHALL compute in one cycle and go to DONE, giving out_valid on the 2nd cycle after the accept edge.
REQ-017 ITER SHALL run exactly W cycles (one bit per cycle), then go to DONE, giving out_valid on cycle W+1 after the accept edge.
REQ-018 ADD SHALL produce zero-extended a+b; the carry appears in bit W.
REQ-019 SUB SHALL produce (zero-extended a minus zero-extended b) modulo 2^(2W).
REQ-020 MUL SHALL produce the full 2W-bit unsigned product by LSB-first shift-add.
REQ-021 DIV with b!=0 SHALL use restoring division and produce result = {remainder, quotient}, with err=0.
REQ-022 DIV with b=0 SHALL produce quotient all-ones and remainder a, with err=1.
REQ-023 err SHALL be 0 for ADD, SUB and MUL.
REQ-024 In DONE, out_valid SHALL be 1 and result/err SHALL hold stable until an edge with out_ready=1.
REQ-025 That out_ready edge SHALL return the FSM to IDLE; no request can be accepted in the same cycle.
REQ-026 out_ready while out_valid=0 SHALL have no effect.
REQ-027 in_valid while busy SHALL be ignored, with no queuing.
REQ-028 The iteration counter SHALL be ceil(log2(W+1)) bits wide and SHALL never wrap inside ITER.

Reset
REQ-029 rst SHALL force IDLE, in_ready=1, out_valid=0, result=0, err=0 and clear the counter and operand registers, at any time including mid-ITER or mid-DONE.
REQ-030 After rst deasserts, the first accept SHALL behave exactly as from power-up; an aborted transaction SHALL produce no output.

Structure
REQ-031 Package seq_arith_pkg SHALL hold the op encoding constants and the FSM state enum.
REQ-032 The iterative datapath (shift-add multiply, restoring divide, counter) SHALL be one sub-module, seq_muldiv_core, with start/done handshaking to the top FSM.
REQ-033 The top level SHALL contain the FSM, the handshake logic, ADD/SUB and output registers, for about 120-400 RTL lines in total.

Verification (W=8)
REQ-034 ADD a=200, b=100 -> result 0x012C, err=0, out_valid 2 cycles after accept.
REQ-035 SUB a=3, b=5 -> result 0xFFFE; MUL a=255, b=255 -> result 0xFE01, out_valid exactly 9 cycles after accept.
REQ-036 DIV a=200, b=7 -> result 0x041C (remainder 4, quotient 28), err=0, latency 9.
REQ-037 DIV a=5, b=0 -> result 0x05FF, err=1, latency 2.
REQ-038 Hold out_ready=0 for 5 cycles after out_valid -> result stable and in_ready=0 throughout; the pulse on the next edge returns in_ready=1.
REQ-039 Assert rst on cycle 4 of MUL -> next cycle out_valid=0, in_ready=1, result=0; a new ADD 1+1 -> result 0x0002.
